multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Moore controller that sequences the shared multicycle MIPS datapath (one ALU, one unified memory).
//  Walks each instruction through FETCH/DECODE/execute/writeback states and drives every datapath mux/enable.
//  Memory states stall on a mem_ready handshake. Sits between the instruction register opcode and the datapath.
// PARAMETERS
//  OP_RTYPE  6'b000000  R-type opcode
//  OP_LW     6'b100011  load word opcode
//  OP_SW     6'b101011  store word opcode
//  OP_BEQ    6'b000100  branch-equal opcode
//  OP_ADDI   6'b001000  add-immediate opcode
//  OP_J      6'b000010  jump opcode
// PORTS
//  clk          in   1  rising-edge clock
//  reset        in   1  asynchronous, active-high reset
//  op           in   6  opcode from instruction register (sampled in DECODE/MEMADR only)
//  mem_ready    in   1  memory completes current access this cycle
//  pc_write     out  1  unconditional PC load
//  branch       out  1  conditional PC load (datapath ANDs with zero)
//  iord         out  1  memory address select: 0=PC, 1=ALUOut
//  mem_write    out  1  memory write strobe
//  ir_write     out  1  instruction register load
//  reg_dst      out  1  write reg select: 0=rt, 1=rd
//  mem_to_reg   out  1  writeback select: 0=ALUOut, 1=Data
//  reg_write    out  1  register file write enable
//  alu_src_a    out  1  0=PC, 1=A
//  alu_src_b    out  2  00=B, 01=const 4, 10=SignImm, 11=SignImm<<2
//  alu_op       out  2  00=add, 01=sub, 10=funct-decoded
//  pc_src       out  2  00=ALUResult, 01=ALUOut, 10=jump target
//  illegal_op   out  1  unsupported opcode seen in DECODE (combinational, that cycle only)
//  state        out  4  current state, debug/verification
// BEHAVIOUR
//  - 4-bit state register; outputs decoded from state only, except pc_write/ir_write in FETCH (qualified by mem_ready) and illegal_op.
//  - Reset: state=FETCH(0) immediately; every output 0 while reset high (incl. pc_write/ir_write/mem_write). Mid-instruction reset aborts, no writeback.
//  - Unlisted outputs are 0 in each state. Encodings/transitions:
//    0 FETCH : src_b=01; ir_write=pc_write=mem_ready. Stay until mem_ready=1 -> DECODE.
//    1 DECODE: src_b=11. RTYPE->EXEC, LW/SW->MEMADR, BEQ->BRANCH, ADDI->ADDIEX, J->JUMP, else illegal_op=1 -> FETCH.
//    2 MEMADR: src_a=1, src_b=10. LW->MEMRD, SW->MEMWR.
//    3 MEMRD : iord=1. Stay until mem_ready -> MEMWB.
//    4 MEMWB : mem_to_reg=1, reg_write=1 -> FETCH.
//    5 MEMWR : iord=1, mem_write=1 held until mem_ready; mem_ready -> FETCH.
//    6 EXEC  : src_a=1, alu_op=10 -> ALUWB.
//    7 ALUWB : reg_dst=1, reg_write=1 -> FETCH.
//    8 BRANCH: src_a=1, alu_op=01, pc_src=01, branch=1 -> FETCH.
//    9 ADDIEX: src_a=1, src_b=10 -> ADDIWB.
//   10 ADDIWB: reg_write=1 -> FETCH.
//   11 JUMP  : pc_src=10, pc_write=1 -> FETCH.
//   12-15: all outputs 0, next FETCH (recovery).
//  - Cycle counts with mem_ready=1 always: R/ADDI 4, LW 5, SW 4, BEQ 3, J 3; each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds one.
//  - mem_ready ignored outside FETCH/MEMRD/MEMWR; op ignored outside DECODE/MEMADR.
// TESTING
//  1 reset high mid-MEMWR -> state=0, mem_write=0 same cycle; after release, FETCH with mem_ready=0 -> ir_write=0, holds.
//  2 op=000000, mem_ready=1 -> states 0,1,6,7,0; ALUWB has reg_dst=1, reg_write=1, alu_op=10 in EXEC.
//  3 op=100011, mem_ready low 2 cycles in MEMRD -> 0,1,2,3,3,3,4,0; MEMWB mem_to_reg=1, reg_write=1.
//  4 op=101011, mem_ready=1 -> 0,1,2,5,0; mem_write=1 and iord=1 only in state 5.
//  5 op=000100 then op=000010 -> 0,1,8,0 with branch=1, pc_src=01; then 0,1,11,0 with pc_write=1, pc_src=10.
//  6 op=111111 -> illegal_op=1 in DECODE only, next state 0, no reg_write/mem_write asserted.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Moore controller for the shared-ALU, unified-memory multicycle MIPS datapath.
// Sequences FETCH/DECODE/execute/writeback and drives every datapath mux and enable.
module multicycle_control_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       branch,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam int unsigned STATE_W = 4;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    state_t r_state;
    state_t w_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    assign state = STATE_W'(r_state);

    // Next state and Moore outputs; FETCH enables and illegal_op also look at inputs.
    always_comb begin
        w_next     = S_FETCH;
        pc_write   = 1'b0;
        branch     = 1'b0;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        illegal_op = 1'b0;

        case (r_state)
            S_FETCH: begin
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                w_next    = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (op)
                    OP_RTYPE:    w_next = S_EXEC;
                    OP_LW,
                    OP_SW:       w_next = S_MEMADR;
                    OP_BEQ:      w_next = S_BRANCH;
                    OP_ADDI:     w_next = S_ADDIEX;
                    OP_J:        w_next = S_JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        w_next     = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord   = 1'b1;
                w_next = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                w_next    = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                branch    = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
            end
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase

        // Reset silences every strobe at once, including the input-qualified ones in FETCH.
        if (reset) begin
            pc_write   = 1'b0;
            branch     = 1'b0;
            iord       = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            reg_write  = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            alu_op     = 2'b00;
            pc_src     = 2'b00;
            illegal_op = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks each instruction class through
// its state sequence and checks the datapath controls against hand-computed values.
module tb_multicycle_control_fsm;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic       mem_ready;
    logic       pc_write, branch, iord, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [3:0] state;

    int checks   = 0;
    int failures = 0;

    multicycle_control_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .branch     (branch),
        .iord       (iord),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .illegal_op (illegal_op),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 2ns after the rising edge.
    task automatic adv();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset     = 1'b1;
        op        = 6'b000000;
        mem_ready = 1'b1;
        #3;
        chk("rst_state",    state,          4'd0);
        chk("rst_ir_write", {3'b0, ir_write}, 4'd0);
        chk("rst_pc_write", {3'b0, pc_write}, 4'd0);
        chk("rst_src_b",    {2'b0, alu_src_b}, 4'd0);

        @(negedge clk);
        reset = 1'b0;
        #1;
        // R-type: 0,1,6,7,0
        chk("r_fetch_state", state,             4'd0);
        chk("r_fetch_irw",   {3'b0, ir_write},  4'd1);
        chk("r_fetch_pcw",   {3'b0, pc_write},  4'd1);
        chk("r_fetch_srcb",  {2'b0, alu_src_b}, 4'd1);
        adv();
        chk("r_decode_state", state,             4'd1);
        chk("r_decode_srcb",  {2'b0, alu_src_b}, 4'd3);
        chk("r_decode_ill",   {3'b0, illegal_op}, 4'd0);
        adv();
        chk("r_exec_state", state,             4'd6);
        chk("r_exec_srca",  {3'b0, alu_src_a}, 4'd1);
        chk("r_exec_aluop", {2'b0, alu_op},    4'd2);
        adv();
        chk("r_aluwb_state",  state,             4'd7);
        chk("r_aluwb_regdst", {3'b0, reg_dst},   4'd1);
        chk("r_aluwb_regwr",  {3'b0, reg_write}, 4'd1);
        adv();
        chk("r_back_fetch", state, 4'd0);

        // LW with two stall cycles in MEMRD: 0,1,2,3,3,3,4,0
        op = 6'b100011;
        adv();
        chk("lw_decode", state, 4'd1);
        adv();
        chk("lw_memadr_state", state,             4'd2);
        chk("lw_memadr_srca",  {3'b0, alu_src_a}, 4'd1);
        chk("lw_memadr_srcb",  {2'b0, alu_src_b}, 4'd2);
        mem_ready = 1'b0;
        adv();
        chk("lw_memrd1_state", state,        4'd3);
        chk("lw_memrd1_iord",  {3'b0, iord}, 4'd1);
        adv();
        chk("lw_memrd2_state", state, 4'd3);
        adv();
        chk("lw_memrd3_state", state, 4'd3);
        mem_ready = 1'b1;
        adv();
        chk("lw_memwb_state", state,              4'd4);
        chk("lw_memwb_m2r",   {3'b0, mem_to_reg}, 4'd1);
        chk("lw_memwb_regwr", {3'b0, reg_write},  4'd1);
        chk("lw_memwb_iord",  {3'b0, iord},       4'd0);
        adv();
        chk("lw_back_fetch", state, 4'd0);

        // SW with mem_ready=1: 0,1,2,5,0
        op = 6'b101011;
        adv();
        chk("sw_decode", state, 4'd1);
        adv();
        chk("sw_memadr_state", state,             4'd2);
        chk("sw_memadr_mw",    {3'b0, mem_write}, 4'd0);
        adv();
        chk("sw_memwr_state", state,             4'd5);
        chk("sw_memwr_mw",    {3'b0, mem_write}, 4'd1);
        chk("sw_memwr_iord",  {3'b0, iord},      4'd1);
        chk("sw_memwr_regwr", {3'b0, reg_write}, 4'd0);
        adv();
        chk("sw_fetch_state", state,             4'd0);
        chk("sw_fetch_mw",    {3'b0, mem_write}, 4'd0);
        chk("sw_fetch_iord",  {3'b0, iord},      4'd0);

        // BEQ: 0,1,8,0
        op = 6'b000100;
        adv();
        chk("beq_decode", state, 4'd1);
        adv();
        chk("beq_state",  state,             4'd8);
        chk("beq_branch", {3'b0, branch},    4'd1);
        chk("beq_pcsrc",  {2'b0, pc_src},    4'd1);
        chk("beq_aluop",  {2'b0, alu_op},    4'd1);
        chk("beq_pcw",    {3'b0, pc_write},  4'd0);
        adv();
        chk("beq_back_fetch", state, 4'd0);

        // J: 0,1,11,0
        op = 6'b000010;
        adv();
        chk("j_decode", state, 4'd1);
        adv();
        chk("j_state",  state,            4'd11);
        chk("j_pcw",    {3'b0, pc_write}, 4'd1);
        chk("j_pcsrc",  {2'b0, pc_src},   4'd2);
        chk("j_branch", {3'b0, branch},   4'd0);
        adv();
        chk("j_back_fetch", state, 4'd0);

        // ADDI: 0,1,9,10,0
        op = 6'b001000;
        adv();
        adv();
        chk("addi_ex_state", state,             4'd9);
        chk("addi_ex_srcb",  {2'b0, alu_src_b}, 4'd2);
        adv();
        chk("addi_wb_state",  state,             4'd10);
        chk("addi_wb_regwr",  {3'b0, reg_write}, 4'd1);
        chk("addi_wb_regdst", {3'b0, reg_dst},   4'd0);
        adv();
        chk("addi_back_fetch", state, 4'd0);

        // Illegal opcode: flagged in DECODE only, straight back to FETCH
        op = 6'b111111;
        adv();
        chk("ill_decode_state", state,              4'd1);
        chk("ill_decode_flag",  {3'b0, illegal_op}, 4'd1);
        chk("ill_decode_regwr", {3'b0, reg_write},  4'd0);
        chk("ill_decode_mw",    {3'b0, mem_write},  4'd0);
        adv();
        chk("ill_fetch_state", state,              4'd0);
        chk("ill_fetch_flag",  {3'b0, illegal_op}, 4'd0);

        // Reset asserted mid-MEMWR aborts the store immediately
        op = 6'b101011;
        adv();
        adv();
        mem_ready = 1'b0;
        adv();
        chk("rstmw_memwr_state", state,             4'd5);
        chk("rstmw_memwr_mw",    {3'b0, mem_write}, 4'd1);
        adv();
        chk("rstmw_hold_state", state, 4'd5);
        #1;
        reset = 1'b1;
        #1;
        chk("rstmw_state", state,             4'd0);
        chk("rstmw_mw",    {3'b0, mem_write}, 4'd0);
        chk("rstmw_iord",  {3'b0, iord},      4'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("stall_fetch_state", state,            4'd0);
        chk("stall_fetch_irw",   {3'b0, ir_write}, 4'd0);
        chk("stall_fetch_pcw",   {3'b0, pc_write}, 4'd0);
        adv();
        chk("stall_hold_state", state,            4'd0);
        chk("stall_hold_irw",   {3'b0, ir_write}, 4'd0);
        mem_ready = 1'b1;
        #1;
        chk("stall_release_irw", {3'b0, ir_write}, 4'd1);
        adv();
        chk("stall_release_decode", state, 4'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
